// File: rtl/shift_pkg.sv
// Shared shift encodings: MIPS funct codes, shifter op select, amount width.
package shift_pkg;
  localparam int AMT_W = 5;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10
  } shift_op_e;

  // Per-entry control word kept in the FIFO alongside the data operand.
  typedef struct packed {
    shift_op_e        op;
    logic [AMT_W-1:0] amt;
  } shift_ctl_t;
endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an R-type shift into shifter operands {legal, op, S, X}.
module shift_decode
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [5:0]       funct,
  input  logic [AMT_W-1:0] shamt,
  input  logic [N-1:0]     rs_data,
  input  logic [N-1:0]     rt_data,
  output logic             legal,
  output shift_op_e        op,
  output logic [31:0]      s,
  output logic [N-1:0]     x
);
  logic [AMT_W-1:0] amt;
  // Only the low amount bits of rs matter to the shifter.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_data[N-1:AMT_W];

  always_comb begin
    legal = 1'b1;
    op    = OP_SLL;
    amt   = shamt;
    unique case (funct)
      FUNCT_SLL:  begin op = OP_SLL; amt = shamt;              end
      FUNCT_SRL:  begin op = OP_SRL; amt = shamt;              end
      FUNCT_SRA:  begin op = OP_SRA; amt = shamt;              end
      FUNCT_SLLV: begin op = OP_SLL; amt = rs_data[AMT_W-1:0]; end
      FUNCT_SRLV: begin op = OP_SRL; amt = rs_data[AMT_W-1:0]; end
      FUNCT_SRAV: begin op = OP_SRA; amt = rs_data[AMT_W-1:0]; end
      default:    legal = 1'b0;
    endcase
  end

  assign s = {{(32-AMT_W){1'b0}}, amt};
  assign x = rt_data;
endmodule

// File: rtl/shift_issue.sv
// Shift decode-and-issue stage: decodes shift instructions into a small FIFO
// feeding the combinational shifter; illegal functs are dropped and counted.
module shift_issue
  import shift_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    funct,
  input  logic [4:0]    shamt,
  input  logic [N-1:0]  rs_data,
  input  logic [N-1:0]  rt_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_X,
  output logic [31:0]   out_S,
  output logic [1:0]    out_op,
  output logic [7:0]    illegal_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic            dec_legal;
  shift_op_e       dec_op;
  logic [31:0]     dec_s;
  logic [N-1:0]    dec_x;

  shift_decode #(.N(N)) u_dec (
    .funct   (funct),
    .shamt   (shamt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .legal   (dec_legal),
    .op      (dec_op),
    .s       (dec_s),
    .x       (dec_x)
  );

  // S is always a zero-extended amount, so only the low bits are stored.
  logic unused_dec_s_hi;
  assign unused_dec_s_hi = ^dec_s[31:AMT_W];

  logic [N-1:0]    mem_x   [DEPTH];
  shift_ctl_t      mem_ctl [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            full, empty, accept, push, pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && dec_legal;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (accept && !dec_legal && illegal_cnt != 8'hFF)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wptr]   <= dec_x;
      mem_ctl[wptr] <= '{op: dec_op, amt: dec_s[AMT_W-1:0]};
    end
  end

  shift_ctl_t head_ctl;
  assign head_ctl  = mem_ctl[rptr];
  assign out_valid = !empty;
  assign out_X     = empty ? '0 : mem_x[rptr];
  assign out_S     = empty ? '0 : {{(32-AMT_W){1'b0}}, head_ctl.amt};
  assign out_op    = empty ? 2'b00 : head_ctl.op;
endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue: handshake, decode, backpressure, illegal counting, reset.
module tb_shift_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_data, rt_data, out_X, out_S;
  logic [1:0]  out_op;
  logic [7:0]  illegal_cnt;

  int n_cmp = 0;
  int n_err = 0;

  shift_issue #(.N(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_X(out_X), .out_S(out_S), .out_op(out_op),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v; funct = f; shamt = sh; rs_data = rs; rt_data = rt;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] x,
                         input logic [31:0] s, input logic [1:0] op);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".X"}, out_X, x);
    chk({tag, ".S"}, out_S, s);
    chk({tag, ".op"}, 32'(out_op), 32'(op));
  endtask

  // Reference decode from the MIPS funct table.
  function automatic logic [1:0] m_op(input logic [5:0] f);
    case (f)
      6'b000000, 6'b000100: return 2'b00;
      6'b000010, 6'b000110: return 2'b01;
      default:              return 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] m_s(input logic [5:0] f, input logic [4:0] sh,
                                      input logic [31:0] rs);
    logic [31:0] r;
    case (f)
      6'b000100, 6'b000110, 6'b000111: r = rs & 32'h1F;
      default:                         r = 32'(sh);
    endcase
    return r;
  endfunction

  logic [5:0]  flist [6] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};
  logic [5:0]  f;
  logic [4:0]  sh;
  logic [31:0] rs, rt;
  int          exp_cnt;

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk_out("reset", 1'b0, 32'd0, 32'd0, 2'b00);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.illegal_cnt", 32'(illegal_cnt), 32'd0);

    // single sll, then pop
    drive(1'b1, 6'b000000, 5'd4, 32'd0, 32'h0000_0001);
    step;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    chk_out("sll", 1'b1, 32'h0000_0001, 32'h0000_0004, 2'b00);
    out_ready = 1'b1;
    step;
    chk_out("sll_pop", 1'b0, 32'd0, 32'd0, 2'b00);

    // srav with junk in upper rs bits
    drive(1'b1, 6'b000111, 5'd17, 32'hFFFF_FFE3, 32'h8000_0000);
    out_ready = 1'b0;
    step;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    chk_out("srav", 1'b1, 32'h8000_0000, 32'h0000_0003, 2'b10);
    out_ready = 1'b1;
    step;
    chk("srav_pop.valid", 32'(out_valid), 32'd0);

    // backpressure: A, B fill the FIFO; C must wait for a pop
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 5'd7, 32'd0, 32'hAAAA_0001);   // A: srl 7
    step;
    chk("bp.ready_after_1", 32'(in_ready), 32'd1);
    drive(1'b1, 6'b000100, 5'd0, 32'd9, 32'hBBBB_0002);   // B: sllv 9
    step;
    chk("bp.ready_after_2", 32'(in_ready), 32'd0);
    drive(1'b1, 6'b000011, 5'd31, 32'd0, 32'hCCCC_0003);  // C: sra 31
    step;
    chk("bp.ready_held", 32'(in_ready), 32'd0);
    chk_out("bp.stable_A", 1'b1, 32'hAAAA_0001, 32'd7, 2'b01);
    out_ready = 1'b1;
    step;
    chk("bp.ready_after_pop", 32'(in_ready), 32'd1);
    chk_out("bp.B", 1'b1, 32'hBBBB_0002, 32'd9, 2'b00);
    step;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    chk_out("bp.C", 1'b1, 32'hCCCC_0003, 32'd31, 2'b10);
    step;
    chk("bp.drained", 32'(out_valid), 32'd0);

    // streaming: one legal instruction per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      f  = flist[$urandom_range(0, 5)];
      sh = 5'($urandom);
      rs = $urandom;
      rt = $urandom;
      drive(1'b1, f, sh, rs, rt);
      step;
      chk_out("stream", 1'b1, rt, m_s(f, sh, rs), m_op(f));
      chk("stream.in_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    step;
    chk("stream.drained", 32'(out_valid), 32'd0);

    // illegal funct interleaved with legal ops; counter saturates at 255
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) begin
        drive(1'b1, 6'b000110, 5'd0, 32'(i / 60 + 1), 32'h5000_0000 + 32'(i));
        step;
        chk_out("illeg.legal", 1'b1, 32'h5000_0000 + 32'(i), 32'(i / 60 + 1), 2'b01);
      end
      drive(1'b1, 6'b100000, 5'd3, 32'd1, 32'hDEAD_BEEF);
      step;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("illeg.no_entry", 32'(out_valid), 32'd0);
      chk("illeg.cnt", 32'(illegal_cnt), 32'(exp_cnt));
    end
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    chk("illeg.saturated", 32'(illegal_cnt), 32'd255);

    // asynchronous reset with two entries queued
    out_ready = 1'b0;
    drive(1'b1, 6'b000000, 5'd1, 32'd0, 32'h1111_1111);
    step;
    drive(1'b1, 6'b000000, 5'd2, 32'd0, 32'h2222_2222);
    step;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    chk("rst.full_before", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst.out_X", out_X, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 6'b000011, 5'd12, 32'd0, 32'h8765_4321);
    step;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0);
    chk_out("post_rst", 1'b1, 32'h8765_4321, 32'd12, 2'b10);
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
